// File: rtl/ddr_rd_demux_pkg.sv
// Shared memory-path definitions for the DDR read demux.
// Bank geometry, FSM encoding and last-beat byte-enable decode.
package ddr_rd_demux_pkg;

  localparam int NUM_BANKS = 16;
  localparam int ADDR_W    = 19;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // 0 selects a full beat; n selects banks [n-1:0]
  function automatic logic [NUM_BANKS-1:0] last_mask(
    input logic [3:0] n
  );
    logic [NUM_BANKS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (n == 4'd0 || i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ddr_rd_demux.sv
// DDR read-data sink: scatters each beat byte-wise
// across the SRAM banks at one common bank address.
module ddr_rd_demux
  import ddr_rd_demux_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_base_addr,
  input  logic [CNT_W-1:0]       cmd_num_beats,
  input  logic [3:0]             cmd_last_valid,
  input  logic                   ddr_rvalid,
  output logic                   ddr_rready,
  input  logic [NUM_BANKS*8-1:0] ddr_rdata,
  input  logic                   ddr_rlast,
  output logic [NUM_BANKS-1:0]   sram_we,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [NUM_BANKS*8-1:0] sram_wdata,
  output logic                   done,
  output logic                   err
);

  state_e            state;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_beats;
  logic [CNT_W-1:0]  beat_idx;
  logic [3:0]        last_valid;
  logic              hs;
  logic              is_last;

  assign cmd_ready  = (state == IDLE);
  assign ddr_rready = (state == ACTIVE);
  assign done       = (state == FLUSH);
  assign hs         = ddr_rvalid & ddr_rready;
  assign is_last    = (beat_idx == num_beats);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_addr  <= '0;
      num_beats  <= '0;
      beat_idx   <= '0;
      last_valid <= '0;
      sram_we    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      err        <= 1'b0;
    end else begin
      sram_we <= '0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            base_addr  <= cmd_base_addr;
            num_beats  <= cmd_num_beats;
            last_valid <= cmd_last_valid;
            beat_idx   <= '0;
            err        <= 1'b0;
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (hs) begin
            sram_we    <= is_last ? last_mask(last_valid) : '1;
            sram_addr  <= base_addr + ADDR_W'(beat_idx);
            sram_wdata <= ddr_rdata;
            // the beat count ends the burst; rlast only flags errors
            if (ddr_rlast != is_last) err <= 1'b1;
            if (is_last) state <= FLUSH;
            else beat_idx <= beat_idx + 1'b1;
          end
        end
        FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_demux.sv
// Scoreboard bench for ddr_rd_demux: expected SRAM
// writes are queued at drive time and popped on output.
module tb_ddr_rd_demux;

  typedef struct packed {
    logic [18:0]  addr;
    logic [15:0]  we;
    logic [127:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [18:0]  cmd_base_addr;
  logic [7:0]   cmd_num_beats;
  logic [3:0]   cmd_last_valid;
  logic         ddr_rvalid;
  logic         ddr_rready;
  logic [127:0] ddr_rdata;
  logic         ddr_rlast;
  logic [15:0]  sram_we;
  logic [18:0]  sram_addr;
  logic [127:0] sram_wdata;
  logic         done;
  logic         err;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  ddr_rd_demux dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_num_beats(cmd_num_beats),
    .cmd_last_valid(cmd_last_valid),
    .ddr_rvalid(ddr_rvalid),
    .ddr_rready(ddr_rready),
    .ddr_rdata(ddr_rdata),
    .ddr_rlast(ddr_rlast),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .done(done),
    .err(err)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1 && sram_we !== 16'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h we=%h",
                 sram_addr, sram_we);
      end else begin
        mon_e = exp_q.pop_front();
        if ({sram_addr, sram_we, sram_wdata} !== mon_e) begin
          errors++;
          $display("FAIL write got a=%h we=%h d=%h want a=%h we=%h d=%h",
                   sram_addr, sram_we, sram_wdata,
                   mon_e.addr, mon_e.we, mon_e.data);
        end
      end
    end
  end

  function automatic logic [15:0] exp_mask(input logic [3:0] lv);
    logic [15:0] one;
    one = 16'h1;
    if (lv == 4'd0) return 16'hFFFF;
    return (one << lv) - 16'd1;
  endfunction

  // Starts and ends at a negedge; drives inputs on negedges.
  task automatic burst(input logic [18:0] base,
                       input logic [7:0] nb,
                       input logic [3:0] lv,
                       input int gap,
                       input int early,
                       input logic last_rlast,
                       input logic exp_err,
                       input string name);
    wr_t e;
    e = '0;
    cmd_valid      = 1'b1;
    cmd_base_addr  = base;
    cmd_num_beats  = nb;
    cmd_last_valid = lv;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready got %b want 1", name, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (ddr_rready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s accept rready=%b err=%b want 1 0",
               name, ddr_rready, err);
    end
    for (int i = 0; i <= int'(nb); i++) begin
      if (i > 0 && gap > 0) begin
        ddr_rvalid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      checks++;
      if (ddr_rready !== 1'b1) begin
        errors++;
        $display("FAIL %s beat%0d rready got %b want 1",
                 name, i, ddr_rready);
      end
      ddr_rdata  = {$urandom, $urandom, $urandom, $urandom};
      ddr_rlast  = (i == early) || (i == int'(nb) && last_rlast);
      ddr_rvalid = 1'b1;
      e.addr = base + 19'(i);
      e.we   = (i == int'(nb)) ? exp_mask(lv) : 16'hFFFF;
      e.data = ddr_rdata;
      exp_q.push_back(e);
      @(negedge clk);
    end
    ddr_rvalid = 1'b0;
    ddr_rlast  = 1'b0;
    checks++;
    if ({done, ddr_rready, cmd_ready, err} !== {3'b100, exp_err}) begin
      errors++;
      $display("FAIL %s flush done/rready/cmd_ready/err got %b%b%b%b want 100%b",
               name, done, ddr_rready, cmd_ready, err, exp_err);
    end
    @(negedge clk);
    checks++;
    if ({done, cmd_ready, err} !== {2'b01, exp_err} ||
        sram_we !== 16'h0 || sram_addr !== e.addr ||
        sram_wdata !== e.data) begin
      errors++;
      $display("FAIL %s idle done=%b cmd_ready=%b err=%b we=%h addr=%h want 0 1 %b 0000 %h",
               name, done, cmd_ready, err, sram_we, sram_addr,
               exp_err, e.addr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_writes got %0d want 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_base_addr  = '0;
    cmd_num_beats  = '0;
    cmd_last_valid = '0;
    ddr_rvalid     = 1'b0;
    ddr_rdata      = '0;
    ddr_rlast      = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, ddr_rready, done, err} !== 4'b1000 ||
        sram_we !== 16'h0 || sram_addr !== 19'h0 ||
        sram_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset rdy=%b rrdy=%b done=%b err=%b we=%h a=%h want 1 0 0 0 0 0",
               cmd_ready, ddr_rready, done, err, sram_we, sram_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || ddr_rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release cmd_ready=%b rready=%b want 1 0",
               cmd_ready, ddr_rready);
    end
  endtask

  task automatic test_basic();
    burst(19'h00100, 8'd3, 4'd0, 0, -1, 1'b1, 1'b0, "basic");
  endtask

  task automatic test_single();
    burst(19'h00200, 8'd0, 4'd5, 0, -1, 1'b1, 1'b0, "single");
    burst(19'h00300, 8'd1, 4'd15, 0, -1, 1'b1, 1'b0, "mask15");
  endtask

  task automatic test_wrap();
    burst(19'h7FFFE, 8'd3, 4'd0, 0, -1, 1'b1, 1'b0, "wrap");
  endtask

  task automatic test_gaps();
    burst(19'h01000, 8'd3, 4'd8, 2, -1, 1'b1, 1'b0, "gaps");
  endtask

  task automatic test_early_rlast();
    burst(19'h02000, 8'd3, 4'd0, 0, 1, 1'b1, 1'b1, "early_rlast");
    burst(19'h02100, 8'd1, 4'd0, 0, -1, 1'b0, 1'b1, "missing_rlast");
    burst(19'h02200, 8'd1, 4'd3, 0, -1, 1'b1, 1'b0, "err_clear");
  endtask

  task automatic test_back_to_back();
    burst(19'h03000, 8'd2, 4'd1, 0, -1, 1'b1, 1'b0, "b2b_a");
    burst(19'h03010, 8'd2, 4'd2, 0, -1, 1'b1, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    wr_t e;
    cmd_valid      = 1'b1;
    cmd_base_addr  = 19'h04000;
    cmd_num_beats  = 8'd3;
    cmd_last_valid = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ddr_rdata  = {$urandom, $urandom, $urandom, $urandom};
      ddr_rlast  = 1'b0;
      ddr_rvalid = 1'b1;
      e.addr = 19'h04000 + 19'(i);
      e.we   = 16'hFFFF;
      e.data = ddr_rdata;
      exp_q.push_back(e);
      @(negedge clk);
    end
    ddr_rvalid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, ddr_rready, done, err} !== 4'b1000 ||
        sram_we !== 16'h0 || sram_addr !== 19'h0 ||
        sram_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid rdy=%b rrdy=%b done=%b err=%b we=%h a=%h want 1 0 0 0 0 0",
               cmd_ready, ddr_rready, done, err, sram_we, sram_addr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_done got %b want 0", done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid pending_writes got %0d want 0",
               exp_q.size());
      exp_q.delete();
    end
    rst_n = 1'b1;
    @(negedge clk);
    burst(19'h04000, 8'd3, 4'd0, 0, -1, 1'b1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_gaps();
    test_early_rlast();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_rd_demux.md
# ddr_rd_demux

Receive-side counterpart of the memory controller's DDR read path. Accepts one burst command (SRAM base address, beat count, valid-byte count of the last beat) and then sinks the DDR read-data beats the controller requested. Each beat is scattered byte-wise across the 16 SRAM banks at one common bank address. Sits between the DDR read-data channel and the SRAM bank write ports; reports completion and protocol errors back to the controller.

## Interface
- NUM_BANKS, 16, SRAM banks; one byte per bank per beat
- ADDR_W, 19, SRAM bank address width
- CNT_W, 8, beat-count width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  high only in IDLE
- cmd_base_addr  in  ADDR_W  SRAM address of beat 0
- cmd_num_beats  in  CNT_W  beats in burst minus 1 (0 = 1 beat)
- cmd_last_valid  in  4  valid bytes in last beat; 0 = all 16
- ddr_rvalid  in  1  read-data beat valid
- ddr_rready  out  1  high only in ACTIVE
- ddr_rdata  in  NUM_BANKS*8  beat; byte i -> bank i
- ddr_rlast  in  1  final beat marker from DDR
- sram_we  out  NUM_BANKS  per-bank write enable, registered
- sram_addr  out  ADDR_W  common bank address, registered
- sram_wdata  out  NUM_BANKS*8  registered beat data
- done  out  1  one-cycle pulse, burst written
- err  out  1  sticky rlast/count mismatch; cleared on next cmd accept

## Operation
- States: IDLE, ACTIVE, FLUSH.
- IDLE: cmd_ready=1. On cmd_valid, latch base_addr, num_beats and last_valid; clear beat counter and err; go to ACTIVE.
- ACTIVE: ddr_rready=1. Each handshake (rvalid & rready) registers one SRAM write:
  - sram_addr = base + beat_idx, mod 2^ADDR_W (wraps silently).
  - sram_wdata = rdata.
  - sram_we = all-ones, except on the beat where beat_idx == num_beats: bits [last_valid-1:0] set, or all-ones if last_valid == 0.
- Burst ends on the counted last beat (beat_idx == num_beats); then go to FLUSH.
- Count is authoritative for ending. ddr_rlast value on the final counted beat is don't-care for termination.
- Error: ddr_rlast=1 on any beat other than the counted last, or ddr_rlast=0 on the counted last, sets err.
  - Early rlast does not end the burst; remaining beats are still accepted.
- FLUSH: last write is on the SRAM port this cycle; done=1; return to IDLE.
- No rvalid in ACTIVE: no write, counter holds; no timeout.
- ddr_rvalid outside ACTIVE is ignored (rready=0).

## Timing
- Reset values: cmd_ready=1, ddr_rready=0, sram_we=0, sram_addr=0, sram_wdata=0, done=0, err=0; state IDLE.
- Cmd accepted at cycle T -> ddr_rready=1 from T+1.
- Beat handshake at cycle k -> sram_we/addr/wdata valid at k+1, for exactly one cycle (sram_we returns to 0 unless another beat is taken).
- Final beat at cycle k -> ddr_rready=0 at k+1; done=1 and final write at k+1; cmd_ready=1 at k+2.
- Back-to-back bursts: minimum gap is 2 cycles from final beat to next cmd accept.
- Single-beat burst (num_beats=0): first beat is the last; last_valid mask applies.
- Reset asserted mid-burst: immediate return to reset values. Partial burst abandoned; no done pulse.
- sram_addr/sram_wdata hold their last value when sram_we=0.

## Structure
- Shared memory package: NUM_BANKS, ADDR_W and the state enum (IDLE/ACTIVE/FLUSH), common with the memory controller.
- Package function: last-beat byte-enable decode (4-bit count -> 16-bit mask, 0 -> all-ones).
- Single module, no sub-modules. The SRAM write register stage is inline.

## Test plan
- Base 0x00100, num_beats=3, last_valid=0, four contiguous beats with rlast on beat 3 -> writes at 0x00100..0x00103, all sram_we=0xFFFF; done at final-beat+1; err=0.
- num_beats=0, last_valid=5, one beat -> single write with sram_we=0x001F; done next cycle.
- Base 0x7FFFE, num_beats=3 -> addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- rvalid gaps (beat, 2 idle cycles, beat, ...) -> one write per beat; no writes on idle cycles; addresses still contiguous.
- rlast on beat 1 of a 4-beat burst -> err=1, all 4 beats written, done asserted; next cmd accept clears err.
- Reset asserted after 2 of 4 beats -> all outputs at reset values immediately, no done. A new cmd after reset completes normally.
